// File: rtl/mac_tx_serializer.sv
// -----------------------------------------------------------------------------
// mac_tx_serializer
//
// Transmit stage that sits behind mac_fifo's 32-bit read port. It pops complete
// frames one word at a time and sends them LSB byte first, one byte per clock.
// Each frame gets a preamble and SFD in front. Frames shorter than
// MIN_FRAME_BYTES are padded with zeros. An inter-frame gap follows every
// transmission and every jam. A collision causes a jam. The fifo is then told
// to rewind the frame (retry), or to drop it once MAX_ATTEMPTS is used up.
//
// Ports
//   i_clock            single clock, one byte per cycle
//   i_reset_n          asynchronous, active-low reset
//   i_fifo_data        fifo word; byte 0 is [7:0]
//   i_fifo_start       current fifo word is the first word of a frame
//   i_fifo_end         current fifo word is the last word of a frame
//   i_fifo_last_bytes  valid bytes in the end word, 0 means 4
//   i_fifo_frame_ready fifo holds at least one complete frame
//   o_fifo_read        pop pulse; fifo word is valid the following cycle
//   o_fifo_retry       pulse: rewind the fifo to the current frame start
//   o_fifo_error       pulse: discard the current frame
//   i_collision        PHY collision detect
//   o_tx_data          byte to the PHY
//   o_tx_enable        o_tx_data is valid
//   o_busy             state machine is not idle
// -----------------------------------------------------------------------------
module mac_tx_serializer #(
    parameter int PREAMBLE_BYTES  = 7,
    parameter int MIN_FRAME_BYTES = 60,
    parameter int IFG_BYTES       = 12,
    parameter int JAM_BYTES       = 4,
    parameter int MAX_ATTEMPTS    = 15
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [31:0] i_fifo_data,
    input  logic        i_fifo_start,
    input  logic        i_fifo_end,
    input  logic [1:0]  i_fifo_last_bytes,
    input  logic        i_fifo_frame_ready,
    output logic        o_fifo_read,
    output logic        o_fifo_retry,
    output logic        o_fifo_error,
    input  logic        i_collision,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_enable,
    output logic        o_busy
);

    localparam int ATT_W = (MAX_ATTEMPTS < 2) ? 1 : $clog2(MAX_ATTEMPTS + 1);

    localparam logic [7:0]       PRE_N = 8'(PREAMBLE_BYTES);
    localparam logic [7:0]       IFG_N = 8'(IFG_BYTES);
    localparam logic [7:0]       JAM_N = 8'(JAM_BYTES);
    localparam logic [6:0]       MIN_N = 7'(MIN_FRAME_BYTES);
    localparam logic [ATT_W-1:0] ATT_N = ATT_W'(MAX_ATTEMPTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PREAMBLE,
        S_SFD,
        S_DATA,
        S_PAD,
        S_JAM,
        S_IFG
    } state_t;

    state_t            r_state;
    logic [31:0]       r_word;       // word being shifted out
    logic              r_word_end;
    logic [1:0]        r_word_last;
    logic [31:0]       r_hold;       // prefetched next word
    logic              r_hold_end;
    logic [1:0]        r_hold_last;
    logic [1:0]        r_byte_idx;   // index of the byte now on o_tx_data
    logic [6:0]        r_bytes;      // DATA+PAD bytes sent, saturating
    logic [7:0]        r_cnt;        // preamble / jam / gap cycle counter
    logic [ATT_W-1:0]  r_attempts;
    logic              r_rd_d;       // a pop was issued last cycle, word valid now
    logic              r_fifo_read;
    logic              r_fifo_retry;
    logic              r_fifo_error;
    logic [7:0]        r_tx_data;
    logic              r_tx_enable;
    logic              r_busy;

    logic [1:0]        w_next_idx;
    logic [7:0]        w_next_byte;
    logic [2:0]        w_word_len;
    logic              w_word_done;
    logic [6:0]        w_bytes_inc;
    logic [ATT_W-1:0]  w_att_inc;
    logic              w_collide;

    assign w_next_idx  = r_byte_idx + 2'd1;
    assign w_next_byte = r_word[{w_next_idx, 3'b000} +: 8];
    assign w_word_len  = (r_word_end && (r_word_last != 2'd0)) ? {1'b0, r_word_last} : 3'd4;
    assign w_word_done = (({1'b0, r_byte_idx} + 3'd1) == w_word_len);
    assign w_bytes_inc = (r_bytes == 7'h7F) ? r_bytes : (r_bytes + 7'd1);
    assign w_att_inc   = (r_attempts == {ATT_W{1'b1}}) ? r_attempts : (r_attempts + ATT_W'(1));

    // Collisions only matter while a frame is actually on the wire; the jam
    // itself and the quiet states ignore the detector.
    assign w_collide = i_collision && r_tx_enable &&
                       ((r_state == S_PREAMBLE) || (r_state == S_SFD) ||
                        (r_state == S_DATA)     || (r_state == S_PAD));

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_word       <= '0;
            r_word_end   <= 1'b0;
            r_word_last  <= '0;
            r_hold       <= '0;
            r_hold_end   <= 1'b0;
            r_hold_last  <= '0;
            r_byte_idx   <= '0;
            r_bytes      <= '0;
            r_cnt        <= '0;
            r_attempts   <= '0;
            r_rd_d       <= 1'b0;
            r_fifo_read  <= 1'b0;
            r_fifo_retry <= 1'b0;
            r_fifo_error <= 1'b0;
            r_tx_data    <= '0;
            r_tx_enable  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_fifo_read  <= 1'b0;
            r_fifo_retry <= 1'b0;
            r_fifo_error <= 1'b0;
            r_rd_d       <= r_fifo_read;

            // Prefetch lands while the current word still has two bytes to go.
            if (r_rd_d && (r_state == S_DATA)) begin
                r_hold      <= i_fifo_data;
                r_hold_end  <= i_fifo_end;
                r_hold_last <= i_fifo_last_bytes;
            end

            if (w_collide) begin
                r_state     <= S_JAM;
                r_tx_data   <= 8'hAA;
                r_tx_enable <= 1'b1;
                r_cnt       <= 8'd1;
                r_attempts  <= w_att_inc;
                r_rd_d      <= 1'b0;   // drop any word still in flight
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_fifo_read) begin
                            r_state <= S_FETCH;
                            r_busy  <= 1'b1;
                        end else if (i_fifo_frame_ready && !r_fifo_retry && !r_fifo_error) begin
                            // Ready may still reflect the frame just retried or
                            // dropped, so wait one cycle after those pulses.
                            r_fifo_read <= 1'b1;
                        end
                    end

                    S_FETCH: begin
                        r_word      <= i_fifo_data;
                        r_word_end  <= i_fifo_end;
                        r_word_last <= i_fifo_last_bytes;
                        if (!i_fifo_start) begin
                            r_fifo_error <= 1'b1;
                            r_state      <= S_IDLE;
                            r_busy       <= 1'b0;
                        end else begin
                            r_state     <= S_PREAMBLE;
                            r_tx_enable <= 1'b1;
                            r_tx_data   <= 8'h55;
                            r_cnt       <= 8'd1;
                        end
                    end

                    S_PREAMBLE: begin
                        if (r_cnt < PRE_N) begin
                            r_cnt <= r_cnt + 8'd1;
                        end else begin
                            r_state   <= S_SFD;
                            r_tx_data <= 8'hD5;
                        end
                    end

                    S_SFD: begin
                        r_state    <= S_DATA;
                        r_tx_data  <= r_word[7:0];
                        r_byte_idx <= 2'd0;
                        r_bytes    <= 7'd1;
                    end

                    S_DATA: begin
                        if (!w_word_done) begin
                            r_tx_data  <= w_next_byte;
                            r_byte_idx <= w_next_idx;
                            r_bytes    <= w_bytes_inc;
                            if ((w_next_idx == 2'd1) && !r_word_end) begin
                                r_fifo_read <= 1'b1;
                            end
                        end else if (!r_word_end) begin
                            r_word      <= r_hold;
                            r_word_end  <= r_hold_end;
                            r_word_last <= r_hold_last;
                            r_tx_data   <= r_hold[7:0];
                            r_byte_idx  <= 2'd0;
                            r_bytes     <= w_bytes_inc;
                        end else if (r_bytes < MIN_N) begin
                            r_state   <= S_PAD;
                            r_tx_data <= 8'h00;
                            r_bytes   <= w_bytes_inc;
                        end else begin
                            r_state     <= S_IFG;
                            r_tx_enable <= 1'b0;
                            r_tx_data   <= 8'h00;
                            r_cnt       <= 8'd1;
                            r_attempts  <= '0;
                        end
                    end

                    S_PAD: begin
                        if (r_bytes < MIN_N) begin
                            r_tx_data <= 8'h00;
                            r_bytes   <= w_bytes_inc;
                        end else begin
                            r_state     <= S_IFG;
                            r_tx_enable <= 1'b0;
                            r_tx_data   <= 8'h00;
                            r_cnt       <= 8'd1;
                            r_attempts  <= '0;
                        end
                    end

                    S_JAM: begin
                        if (r_cnt < JAM_N) begin
                            r_cnt <= r_cnt + 8'd1;
                        end else begin
                            r_state     <= S_IFG;
                            r_tx_enable <= 1'b0;
                            r_tx_data   <= 8'h00;
                            r_cnt       <= 8'd1;
                            if (r_attempts < ATT_N) begin
                                r_fifo_retry <= 1'b1;
                            end else begin
                                r_fifo_error <= 1'b1;
                                r_attempts   <= '0;
                            end
                        end
                    end

                    S_IFG: begin
                        if (r_cnt < IFG_N) begin
                            r_cnt <= r_cnt + 8'd1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            // Issue the pop as the gap ends so the read lands
                            // exactly IFG_BYTES cycles after tx_enable fell.
                            if (i_fifo_frame_ready) begin
                                r_fifo_read <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_fifo_read  = r_fifo_read;
    assign o_fifo_retry = r_fifo_retry;
    assign o_fifo_error = r_fifo_error;
    assign o_tx_data    = r_tx_data;
    assign o_tx_enable  = r_tx_enable;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_mac_tx_serializer.sv
// -----------------------------------------------------------------------------
// Bench for mac_tx_serializer. A small fifo model feeds frames. Expected PHY
// bytes are queued when a frame is loaded and compared as tx_enable bytes
// appear. Frame lengths/read counts come from a table; collision, attempt
// limit, bad start and mid-frame reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mac_tx_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] f_data = '0;
    logic        f_start = 1'b0;
    logic        f_end = 1'b0;
    logic [1:0]  f_last = '0;
    logic        f_ready;
    logic        collision = 1'b0;
    logic        rd, retry, err, txen, busy;
    logic [7:0]  txd;

    always #5 clk = ~clk;

    mac_tx_serializer #(.MAX_ATTEMPTS(2)) dut (
        .i_clock            (clk),
        .i_reset_n          (rst_n),
        .i_fifo_data        (f_data),
        .i_fifo_start       (f_start),
        .i_fifo_end         (f_end),
        .i_fifo_last_bytes  (f_last),
        .i_fifo_frame_ready (f_ready),
        .o_fifo_read        (rd),
        .o_fifo_retry       (retry),
        .o_fifo_error       (err),
        .i_collision        (collision),
        .o_tx_data          (txd),
        .o_tx_enable        (txen),
        .o_busy             (busy)
    );

    // ---------------- fifo model ----------------
    typedef struct {
        logic [31:0] data;
        logic        st;
        logic        en;
        logic [1:0]  lb;
        int          base;
        int          nxt;
    } fword_t;

    fword_t mem [0:511];
    int     wr_ptr = 0;
    int     rd_ptr = 0;
    int     cur_word = 0;
    logic   rewind_req = 1'b0;

    assign f_ready = (rd_ptr < wr_ptr);

    always @(posedge clk) begin
        if (rd) begin
            f_data   <= mem[rd_ptr].data;
            f_start  <= mem[rd_ptr].st;
            f_end    <= mem[rd_ptr].en;
            f_last   <= mem[rd_ptr].lb;
            cur_word <= rd_ptr;
            rd_ptr   <= rd_ptr + 1;
        end
        if (retry || rewind_req) rd_ptr <= mem[cur_word].base;
        if (err)                 rd_ptr <= mem[cur_word].nxt;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [7:0] fb(input int seed, input int k);
        return 8'((seed + k + 1) & 255);
    endfunction

    task automatic push_head();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
    endtask

    task automatic push_frame(input int nbytes, input int seed);
        push_head();
        for (int k = 0; k < nbytes; k++) exp_q.push_back(fb(seed, k));
        for (int k = nbytes; k < 60; k++) exp_q.push_back(8'h00);
    endtask

    task automatic push_partial(input int seed, input int ndata, input bit jam);
        push_head();
        for (int k = 0; k < ndata; k++) exp_q.push_back(fb(seed, k));
        if (jam) for (int i = 0; i < 4; i++) exp_q.push_back(8'hAA);
    endtask

    task automatic load_frame(input int nbytes, input int seed, input bit bad_start);
        int nw;
        int base;
        nw = (nbytes + 3) / 4;
        base = wr_ptr;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] d;
            for (int b = 0; b < 4; b++)
                d[b*8 +: 8] = (w*4 + b < nbytes) ? fb(seed, w*4 + b) : 8'hEE;
            mem[base + w].data = d;
            mem[base + w].st   = (w == 0) && !bad_start;
            mem[base + w].en   = (w == nw - 1);
            mem[base + w].lb   = 2'(nbytes % 4);
            mem[base + w].base = base;
            mem[base + w].nxt  = base + nw;
        end
        wr_ptr = base + nw;
    endtask

    // ---------------- monitor ----------------
    int cyc = 0;
    int run_len = 0;
    int last_run = 0;
    int runs_done = 0;
    int n_reads = 0;
    int n_retry = 0;
    int n_error = 0;
    int last_read_cyc = 0;
    int rise_delay = 0;
    int fall_cyc = 0;
    int gap_rd = 0;
    bit pending_fall = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rd) begin
                n_reads++;
                last_read_cyc = cyc;
                if (pending_fall) begin
                    gap_rd = cyc - fall_cyc;
                    pending_fall = 0;
                end
            end
            if (retry) n_retry++;
            if (err)   n_error++;
            if (retry || err)
                check(!(retry && err) && !rd, "pulse_excl", {retry, err, rd}, retry ? 3'b100 : 3'b010);
            if (txen) begin
                if (run_len == 0) rise_delay = cyc - last_read_cyc;
                run_len++;
                if (exp_q.size() == 0) check(1'b0, "sb_empty", txd, 0);
                else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check(txd == e, "tx_byte", txd, e);
                end
            end else if (run_len != 0) begin
                last_run = run_len;
                run_len = 0;
                runs_done++;
                fall_cyc = cyc;
                pending_fall = 1;
            end
        end
    end

    task automatic wait_runs(input int target, input string name);
        int k = 0;
        while (runs_done < target && k < 3000) begin
            @(negedge clk); #1;
            k++;
        end
        check(runs_done >= target, name, runs_done, target);
    endtask

    task automatic wait_frame_start();
        int k = 0;
        while (txen && k < 500) begin @(negedge clk); k++; end
        k = 0;
        while (!txen && k < 500) begin @(negedge clk); k++; end
        check(txen == 1'b1, "tx_start_wait", txen, 1);
    endtask

    task automatic collide_at(input int offset);
        wait_frame_start();
        repeat (offset) @(posedge clk);
        #1 collision = 1'b1;
        @(posedge clk);
        #1 collision = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        int nbytes;
        int seed;
        int exp_txen;
        int exp_reads;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int snap_reads, snap_runs, snap_err, snap_retry, gap;

        vecs[0] = '{4,   0,  68,  1};
        vecs[1] = '{65,  16, 73,  17};
        vecs[2] = '{1,   40, 68,  1};
        vecs[3] = '{60,  3,  68,  15};
        vecs[4] = '{61,  7,  69,  16};
        vecs[5] = '{6,   9,  68,  2};
        vecs[6] = '{130, 1,  138, 33};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check(txd == 8'h00, "rst_tx_data", txd, 0);
        check({txen, rd, retry, err, busy} == 5'b0, "rst_ctrl", {txen, rd, retry, err, busy}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1 check({busy, rd} == 2'b00, "idle_no_frame", {busy, rd}, 0);

        // table-driven frames
        for (int i = 0; i < 7; i++) begin
            snap_reads = n_reads;
            snap_runs  = runs_done;
            push_frame(vecs[i].nbytes, vecs[i].seed);
            load_frame(vecs[i].nbytes, vecs[i].seed, 1'b0);
            wait_runs(snap_runs + 1, "frame_done");
            check(last_run == vecs[i].exp_txen, "txen_len", last_run, vecs[i].exp_txen);
            check(rise_delay == 2, "read_to_preamble", rise_delay, 2);
            gap = 0;
            while (busy && gap < 100) begin
                gap++;
                @(negedge clk); #1;
            end
            check(gap == 12, "ifg_len", gap, 12);
            check(n_reads - snap_reads == vecs[i].exp_reads, "read_count", n_reads - snap_reads, vecs[i].exp_reads);
        end

        // first word without start marker: dropped, nothing sent
        snap_err  = n_error;
        snap_runs = runs_done;
        load_frame(4, 99, 1'b1);
        repeat (20) @(negedge clk);
        #1;
        check(n_error - snap_err == 1, "bad_start_error", n_error - snap_err, 1);
        check(runs_done == snap_runs && run_len == 0, "bad_start_no_tx", runs_done - snap_runs, 0);
        check(busy == 1'b0, "bad_start_idle", busy, 0);

        // collision in data byte 3, then a clean retry
        snap_runs  = runs_done;
        snap_retry = n_retry;
        snap_err   = n_error;
        push_partial(20, 3, 1'b1);
        push_frame(8, 20);
        load_frame(8, 20, 1'b0);
        collide_at(10);
        wait_runs(snap_runs + 1, "jam_done");
        check(last_run == 15, "jam_run_len", last_run, 15);
        wait_runs(snap_runs + 2, "retry_done");
        check(gap_rd == 12, "ifg_to_read", gap_rd, 12);
        check(last_run == 68, "retry_run_len", last_run, 68);
        check(n_retry - snap_retry == 1, "retry_count", n_retry - snap_retry, 1);
        check(n_error == snap_err, "retry_no_error", n_error - snap_err, 0);

        // attempt limit (2): retry, then drop; next frame goes out normally
        snap_runs  = runs_done;
        snap_retry = n_retry;
        snap_err   = n_error;
        push_partial(50, 3, 1'b1);
        push_partial(50, 3, 1'b1);
        push_frame(10, 90);
        load_frame(12, 50, 1'b0);
        load_frame(10, 90, 1'b0);
        collide_at(10);
        collide_at(10);
        wait_runs(snap_runs + 3, "limit_done");
        check(n_retry - snap_retry == 1, "limit_retry", n_retry - snap_retry, 1);
        check(n_error - snap_err == 1, "limit_error", n_error - snap_err, 1);
        check(last_run == 68, "after_drop_len", last_run, 68);

        // asynchronous reset during data, then a fresh fetch
        snap_runs = runs_done;
        push_partial(70, 4, 1'b0);
        push_frame(40, 70);
        load_frame(40, 70, 1'b0);
        wait_frame_start();
        repeat (12) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check(txd == 8'h00, "async_rst_data", txd, 0);
        check({txen, rd, retry, err, busy} == 5'b0, "async_rst_ctrl", {txen, rd, retry, err, busy}, 0);
        rewind_req = 1'b1;
        @(posedge clk);
        #1 rewind_req = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1 check(rd == 1'b1, "read_after_reset", rd, 1);
        wait_runs(snap_runs + 2, "reset_resend");
        check(last_run == 68, "resend_len", last_run, 68);

        repeat (20) @(negedge clk);
        check(exp_q.size() == 0, "sb_leftover", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
